// File: rtl/div_iter.sv
`timescale 1ns/1ps
// div_iter: iterative 32-bit divider for the Execute stage.
// It uses a restoring shift-subtract on operand magnitudes, producing one
// quotient bit per cycle, MSB first.
// A zero divisor skips the loop: the result is {opa, 32'hFFFFFFFF}.
// Optional feature macro: DIV_SIGNED_EN. When it is defined, signed_div selects
// two's-complement division. Without it, every divide is unsigned and the
// sign-correction logic is not built.
//
// Handshake: start is a level held by the stalled instruction. An operation is
// accepted only in IDLE when start=1 and cancel=0. stall_div stays high until
// the DONE cycle. ready is high for exactly that DONE cycle, and result is valid
// and held from then on. cancel drops stall_div combinationally and returns the
// block to IDLE on the next edge.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_div,
    input  logic        cancel,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall_div,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIVZ = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_count;
    logic [31:0] r_rem;     // partial remainder (always below divisor)
    logic [31:0] r_quo;     // dividend bits shifting out, quotient bits shifting in
    logic [31:0] r_div;     // divisor magnitude
    logic [31:0] r_opa;     // raw dividend, returned as remainder on divide-by-zero
    logic [63:0] r_result;

    logic        w_accept;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_n;
    logic [31:0] w_quo_n;
    logic [31:0] w_q_fin;
    logic [31:0] w_r_fin;

    assign w_accept = (r_state == IDLE) & start & ~cancel;

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_neg_a;
    logic w_neg_b;

    assign w_neg_a = signed_div & opa[31];
    assign w_neg_b = signed_div & opb[31];
    assign w_mag_a = w_neg_a ? (32'd0 - opa) : opa;
    assign w_mag_b = w_neg_b ? (32'd0 - opb) : opb;

    // Remember the result signs: the quotient is negative when the operand
    // signs differ, and the remainder follows the dividend's sign.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
        end
    end

    assign w_q_fin = r_neg_q ? (32'd0 - w_quo_n) : w_quo_n;
    assign w_r_fin = r_neg_r ? (32'd0 - w_rem_n) : w_rem_n;
`else
    logic w_unused_signed;

    assign w_unused_signed = signed_div;
    assign w_mag_a = opa;
    assign w_mag_b = opb;
    assign w_q_fin = w_quo_n;
    assign w_r_fin = w_rem_n;
`endif

    // The 33-bit shifted remainder is at most 2*div-1. A set bit 32 in the
    // difference therefore means the divisor did not fit.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_diff[32];
    assign w_rem_n = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_n = {r_quo[30:0], w_ge};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic; cancel overrides everything.
    always_comb begin
        w_next = r_state;
        if (cancel) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (start) w_next = (opb == 32'd0) ? DIVZ : BUSY;
                DIVZ: w_next = DONE;
                BUSY: if (r_count == 5'd31) w_next = DONE;
                DONE: w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Datapath: latch operands, iterate, and register the final result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count  <= 5'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_div    <= 32'd0;
            r_opa    <= 32'd0;
            r_result <= 64'd0;
        end else if (w_accept) begin
            r_count <= 5'd0;
            r_rem   <= 32'd0;
            r_quo   <= w_mag_a;
            r_div   <= w_mag_b;
            r_opa   <= opa;
        end else if (!cancel) begin
            if (r_state == BUSY) begin
                r_rem   <= w_rem_n;
                r_quo   <= w_quo_n;
                r_count <= r_count + 5'd1;
                if (r_count == 5'd31) r_result <= {w_r_fin, w_q_fin};
            end else if (r_state == DIVZ) begin
                r_result <= {r_opa, 32'hFFFF_FFFF};
            end
        end
    end

    // Output decode.
    always_comb begin
        ready     = (r_state == DONE);
        stall_div = w_accept | (((r_state == BUSY) | (r_state == DIVZ)) & ~cancel);
    end

    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_div_iter.sv
`timescale 1ns/1ps
// tb_div_iter: randomized and directed divides checked against an arithmetic model.
module tb_div_iter;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        cancel;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [63:0] result;
  logic        ready;
  logic        stall_div;
  logic [1:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .cancel     (cancel),
    .opa        (opa),
    .opb        (opb),
    .result     (result),
    .ready      (ready),
    .stall_div  (stall_div),
    .dbg_state  (dbg_state)
  );

  // behavioural model: plain arithmetic
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [31:0] uq;
    logic [31:0] ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every ready pulse must match the oldest expected result
  always @(negedge clk) begin
    if (resetn === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(ready), 64'd0);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // driver: called at #1 after a posedge; returns at #1 after a posedge
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    int          lat;
    bit          done;
    logic [63:0] e;
    lat  = (b == 32'd0) ? 2 : 33;
    e    = model(a, b, sgn);
    opa  = a;
    opb  = b;
    signed_div = sgn;
    start = 1'b1;
    exp_q.push_back(e);
    done = 1'b0;
    for (int k = 0; k <= 40 && !done; k++) begin
      @(negedge clk);
      check("stall_cycle", 64'(stall_div), 64'(k < lat));
      check("ready_cycle", 64'(ready), 64'(k == lat));
      if (k == lat || ready === 1'b1) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) check("ready_timeout", 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    opa   = $urandom;
    opb   = $urandom;
    @(negedge clk);
    check("result_hold", result, e);
    check("ready_after", 64'(ready), 64'd0);
    check("stall_after", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_cancel(input logic [31:0] a, input logic [31:0] b, input int at);
    opa = a;
    opb = b;
    signed_div = 1'b0;
    start = 1'b1;
    for (int k = 0; k < at; k++) begin
      @(posedge clk);
      #1;
    end
    cancel = 1'b1;
    #1;
    check("cancel_stall", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    start  = 1'b0;
    check("cancel_idle", 64'(dbg_state), 64'd0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("cancel_no_ready", 64'(ready), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_reset(input logic [31:0] a, input logic [31:0] b, input int at);
    opa = a;
    opb = b;
    signed_div = 1'b0;
    start = 1'b1;
    for (int k = 0; k < at; k++) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b0;
    #1;
    check("rst_result", result, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_stall_start", 64'(stall_div), 64'd1);
    start = 1'b0;
    #1;
    check("rst_stall_nostart", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    signed_div = 1'b0;
    cancel = 1'b0;
    opa = 32'd0;
    opb = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_stall", 64'(stall_div), 64'd0);
    start = 1'b1;
    #1;
    check("reset_stall_start", 64'(stall_div), 64'd1);
    start = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // hand-computed pins on the model itself
    check("pin_100_7", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    check("pin_m7_2", model(32'hFFFF_FFF9, 32'd2, 1'b1),
          SIGNED_EN ? {32'hFFFF_FFFF, 32'hFFFF_FFFD} : {32'd1, 32'h7FFF_FFFC});
    check("pin_min_m1", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),
          SIGNED_EN ? {32'h0, 32'h8000_0000} : {32'h8000_0000, 32'h0});
    check("pin_5_0", model(32'd5, 32'd0, 1'b0), {32'h5, 32'hFFFF_FFFF});

    // start together with cancel in IDLE is not accepted
    opa = 32'd10;
    opb = 32'd3;
    start = 1'b1;
    cancel = 1'b1;
    #1;
    check("idle_cancel_stall", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
    check("idle_cancel_state", 64'(dbg_state), 64'd0);
    start = 1'b0;
    cancel = 1'b0;
    @(posedge clk);
    #1;

    // directed divides
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div(32'd5, 32'd0, 1'b0);
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1);
    run_div(32'd0, 32'd5, 1'b0);
    run_div(32'd7, 32'd100, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1);

    // cancel mid-operation, then a normal divide
    run_cancel(32'd1000, 32'd3, 10);
    run_div(32'd9, 32'd3, 1'b0);

    // reset mid-operation, then a normal divide
    run_reset(32'd12345, 32'd67, 15);
    run_div(32'd12345, 32'd67, 1'b0);

    // randomized divides
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'd0;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  a div/divu instruction occupies the Execute stage; held high while that instruction is stalled in Execute.
REQ-005 signed_div  input  1  1 = div (two's complement), 0 = divu; sampled with start in IDLE.
REQ-006 cancel  input  1  Execute-stage flush; abandons any operation in progress.
REQ-007 opa  input  32  dividend (rs value after forwarding); sampled with start in IDLE.
REQ-008 opb  input  32  divisor (rt value after forwarding); sampled with start in IDLE.
REQ-009 result  output  64  {remainder[63:32] (to HI), quotient[31:0] (to LO)}; registered.
REQ-010 ready  output  1  result valid; single-cycle pulse in DONE.
REQ-011 stall_div  output  1  stall request to the hazard unit (stalls F/D/E/M/W).

Function
REQ-012 FSM states SHALL be IDLE, DIVZ, BUSY and DONE.
REQ-013 In IDLE with start=1 and cancel=0, the block SHALL latch the operands and go to DIVZ if opb==0, otherwise to BUSY with count=0.
REQ-014 BUSY SHALL run 32 cycles of restoring shift-subtract on a 33-bit partial remainder, one quotient bit per cycle, MSB first, and go to DONE when count==31.
REQ-015 DIVZ SHALL last one cycle, load result={opa, 32'hFFFFFFFF} and go to DONE.
REQ-016 DONE SHALL assert ready for exactly one cycle, hold result, and return to IDLE.
REQ-017 stall_div SHALL be (start & state==IDLE & ~cancel) | state==BUSY | state==DIVZ, and SHALL be 0 in DONE so that Execute advances on that edge.
REQ-018 Latency SHALL be start-accepted at cycle 0, ready at cycle 33 for a normal divide, and ready at cycle 2 for a zero divisor.
REQ-019 For signed operation, the core SHALL divide magnitudes; the quotient is negated when opa[31]^opb[31], the remainder takes the sign of opa, and the remainder magnitude is always below |opb|.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 with no special state.
REQ-021 cancel=1 in any state SHALL force IDLE on the next edge, clear ready, and deassert stall_div combinationally in the same cycle.
REQ-022 start=1 in DONE SHALL be ignored; a new operation is accepted only from IDLE.
REQ-023 result SHALL retain its last value until the next DIVZ or BUSY completion.

Reset
REQ-024 While resetn=0 the block SHALL hold state=IDLE, count=0, result=0, ready=0 and internal operand registers at 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation immediately; stall_div then depends only on start, as in IDLE.

Configuration
REQ-026 With DIV_SIGNED_EN defined, signed_div SHALL select signed operation as in REQ-019 and REQ-020.
REQ-027 Without DIV_SIGNED_EN, signed_div SHALL be ignored, all divides SHALL be unsigned, and the sign-correction logic SHALL be absent.

Verification
REQ-028 Unsigned 100/7 (start at cycle 0) -> stall_div high for cycles 0-32, ready at cycle 33, result={32'd2, 32'd14}.
REQ-029 Signed -7/2 (0xFFFFFFF9/0x2) -> result={32'hFFFFFFFF, 32'hFFFFFFFD}; without DIV_SIGNED_EN -> quotient 0x7FFFFFFC, remainder 1.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> result={32'h0, 32'h80000000} at cycle 33.
REQ-031 Divide 5/0 -> ready at cycle 2, result={32'h5, 32'hFFFFFFFF}, stall_div high for cycles 0-1 only.
REQ-032 cancel pulsed at cycle 10 of a divide -> stall_div low in cycle 10, IDLE at cycle 11, no ready pulse, and a following 9/3 divide returns {0, 3}.
REQ-033 resetn pulsed low at cycle 15 of a divide -> result=0 and ready=0 immediately, and a following divide completes normally.
